// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg
// Shared state encoding and default widths for the bit-serial sequence link.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int C_SEQ_N  = 6;
    localparam int C_SEQ_CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_gen.sv
// ============================================================================
// seq_gen
// Serial pattern transmitter: shifts an N-bit pattern out MSB-first for a
// latched number of repetitions. SEQ_GEN_GAP_EN inserts one idle cycle
// between repetitions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_gen
    import seq_pkg::*;
#(
    parameter int N  = C_SEQ_N,
    parameter int CW = C_SEQ_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [N-1:0]  seq,
    input  logic [CW-1:0] reps,
    output logic          a,
    output logic          bit_valid,
    output logic          busy,
    output logic          done
);

    localparam int            IW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] C_IDX_TOP = IW'(N - 1);

    state_t        r_state;
    logic [N-1:0]  r_pat;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_rep;

    // r_idx always names the bit currently presented on a.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_idx     <= '0;
            r_rep     <= '0;
            a         <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    a         <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        r_pat <= seq;
                        r_idx <= C_IDX_TOP;
                        r_rep <= reps;
                        if (reps != '0) begin
                            r_state   <= SHIFT;
                            a         <= seq[N-1];
                            bit_valid <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                        a     <= r_pat[r_idx - 1'b1];
                    end else if (r_rep > CW'(1)) begin
                        r_rep <= r_rep - 1'b1;
`ifdef SEQ_GEN_GAP_EN
                        r_state   <= GAP;
                        a         <= 1'b0;
                        bit_valid <= 1'b0;
`else
                        r_idx <= C_IDX_TOP;
                        a     <= r_pat[N-1];
`endif
                    end else begin
                        r_rep     <= '0;
                        r_state   <= IDLE;
                        a         <= 1'b0;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    r_state   <= SHIFT;
                    r_idx     <= C_IDX_TOP;
                    a         <= r_pat[N-1];
                    bit_valid <= 1'b1;
                end
`endif
                default: begin
                    r_state   <= IDLE;
                    a         <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_gen.sv
// ============================================================================
// tb_seq_gen
// Directed self-checking bench for seq_gen.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_gen;
    import seq_pkg::*;

    localparam int N    = C_SEQ_N;
    localparam int CW   = C_SEQ_CW;
    localparam int MAXC = 200;
`ifdef SEQ_GEN_GAP_EN
    localparam int GAPS = 1;
`else
    localparam int GAPS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  seq = '0;
    logic [CW-1:0] reps = '0;
    logic          a, bit_valid, busy, done;

    int errors = 0;
    int checks = 0;

    seq_gen #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .seq       (seq),
        .reps      (reps),
        .a         (a),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from the cycle start is raised until done (or budget),
    // modelling the receiving detector's shift register along the way.
    task automatic capture(input logic [N-1:0] s, input logic [CW-1:0] r,
                           input int pulse_at,
                           output int done_cyc, output int nbits,
                           output logic [63:0] bits, output int gaps,
                           output int busy_cyc, output int bad,
                           output logic [63:0] hits);
        logic [N-1:0] det;
        seq = s; reps = r; start = 1'b1;
        done_cyc = -1; nbits = 0; bits = '0; gaps = 0; busy_cyc = 0;
        bad = 0; hits = '0; det = '0;
        for (int c = 1; c <= MAXC && done_cyc < 0; c++) begin
            step();
            start = (c == pulse_at);
            seq   = ~s;
            reps  = '0;
            if (bit_valid) begin
                nbits++;
                bits = {bits[62:0], a};
                det  = {det[N-2:0], a};
                if (det == s && nbits < 64) hits[nbits] = 1'b1;
            end
            if (busy && !bit_valid) gaps++;
            if (busy) busy_cyc++;
            if ((a && !bit_valid) || (bit_valid && !busy) || (done && busy)) bad++;
            if (done) done_cyc = c;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        step(); step();
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({a, bit_valid, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle[%0d]: outputs=%b expected=0000", i, {a, bit_valid, busy, done});
            end
        end
    endtask

    task automatic test_single();
        int dc, nb, gp, bc, bd;
        logic [63:0] bits, hits;
        capture(6'b101101, 4'd1, 0, dc, nb, bits, gp, bc, bd, hits);
        checks++; if (dc !== 7) begin errors++; $display("FAIL single_done_cycle: got %0d expected 7", dc); end
        checks++; if (nb !== 6) begin errors++; $display("FAIL single_nbits: got %0d expected 6", nb); end
        checks++; if (bits[5:0] !== 6'b101101) begin errors++; $display("FAIL single_bits: got %b expected 101101", bits[5:0]); end
        checks++; if (bc !== 6) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 6", bc); end
        checks++; if (bd !== 0) begin errors++; $display("FAIL single_consistency: got %0d bad cycles expected 0", bd); end
        step();
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL single_done_pulse: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
    endtask

    task automatic test_two_reps();
        int dc, nb, gp, bc, bd;
        logic [63:0] bits, hits;
        capture(6'b110010, 4'd2, 0, dc, nb, bits, gp, bc, bd, hits);
        checks++; if (dc !== 13 + GAPS) begin errors++; $display("FAIL two_done_cycle: got %0d expected %0d", dc, 13 + GAPS); end
        checks++; if (nb !== 12) begin errors++; $display("FAIL two_nbits: got %0d expected 12", nb); end
        checks++; if (bits[11:0] !== 12'b110010110010) begin errors++; $display("FAIL two_bits: got %b expected 110010110010", bits[11:0]); end
        checks++; if (gp !== GAPS) begin errors++; $display("FAIL two_gaps: got %0d expected %0d", gp, GAPS); end
        checks++; if (hits !== 64'h1040) begin errors++; $display("FAIL two_detector_hits: got %h expected 1040", hits); end
        checks++; if (bd !== 0) begin errors++; $display("FAIL two_consistency: got %0d bad cycles expected 0", bd); end
    endtask

    task automatic test_zero_and_ignore();
        int dc, nb, gp, bc, bd;
        logic [63:0] bits, hits;
        capture(6'b111111, 4'd0, 0, dc, nb, bits, gp, bc, bd, hits);
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", dc); end
        checks++; if (nb !== 0 || bc !== 0) begin errors++; $display("FAIL zero_no_bits: got bits=%0d busy=%0d expected 0 0", nb, bc); end
        capture(6'b101101, 4'd3, 5, dc, nb, bits, gp, bc, bd, hits);
        checks++; if (dc !== 19 + 2 * GAPS) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected %0d", dc, 19 + 2 * GAPS); end
        checks++; if (nb !== 18) begin errors++; $display("FAIL ignore_nbits: got %0d expected 18", nb); end
        checks++; if (bits[17:0] !== 18'b101101101101101101) begin errors++; $display("FAIL ignore_bits: got %b expected 101101101101101101", bits[17:0]); end
        step();
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL ignore_after: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
    endtask

    task automatic test_reset_mid();
        int dc, nb, gp, bc, bd;
        logic [63:0] bits, hits;
        seq = 6'b101101; reps = 4'd2; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        checks++;
        if ({a, bit_valid, busy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_bit3: outputs=%b expected=111", {a, bit_valid, busy});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async_clear: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
        step(); step();
        reset_n = 1'b1;
        step();
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_no_done: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
        capture(6'b110010, 4'd1, 0, dc, nb, bits, gp, bc, bd, hits);
        checks++; if (dc !== 7) begin errors++; $display("FAIL mid_fresh_done: got %0d expected 7", dc); end
        checks++; if (nb !== 6 || bits[5:0] !== 6'b110010) begin errors++; $display("FAIL mid_fresh_bits: got %0d bits %b expected 6 bits 110010", nb, bits[5:0]); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pat;
        logic [3:0]   exp;
        int           p;
        pat = 6'b101101;
        seq = pat; reps = 4'd1; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c == 21) start = 1'b0;
            p = (c - 1) % (N + 1);
            exp = (p < N) ? {pat[N-1-p], 3'b110} : 4'b0001;
            checks++;
            if ({a, bit_valid, busy, done} !== exp) begin
                errors++;
                $display("FAIL b2b_cycle[%0d]: outputs=%b expected=%b", c, {a, bit_valid, busy, done}, exp);
            end
        end
        step();
        checks++;
        if ({a, bit_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_stop: outputs=%b expected=0000", {a, bit_valid, busy, done});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_reps();
        test_zero_and_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
